// File: rtl/d_branch_resolve_unit_if.sv
// Decode-stage branch handshake between the D stage and the branch resolver.
// The D stage presents the branch and its operands; the resolver answers with stall and decision.
interface d_branch_resolve_unit_if #(
    parameter int WIDTH = 32
);
    logic             br_valid;
    logic [2:0]       br_op;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             rd1_ready;
    logic             rd2_ready;
    logic             flush;
    logic             cmp_stall;
    logic             b_done;
    logic             b_jump;

    modport master (
        output br_valid, br_op, rd1, rd2, rd1_ready, rd2_ready, flush,
        input  cmp_stall, b_done, b_jump
    );

    modport slave (
        input  br_valid, br_op, rd1, rd2, rd1_ready, rd2_ready, flush,
        output cmp_stall, b_done, b_jump
    );
endinterface

// File: rtl/d_branch_resolve_unit.sv
// Decode-stage branch resolver: waits for forwardable operands, evaluates the MIPS
// condition (signed) and delivers a one-cycle registered decision plus saturating stats.
//
// state   | meaning
// IDLE    | no branch in flight; resolves immediately if operands are ready
// WAIT    | branch present, waiting for a needed operand to become final
// RESOLVE | b_done/b_jump valid this cycle; D register advances
module d_branch_resolve_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    d_branch_resolve_unit_if.slave bus,
    input  logic                   clr_cnt,
    output logic [CNT_W-1:0]       cnt_branch,
    output logic [CNT_W-1:0]       cnt_taken,
    output logic [CNT_W-1:0]       cnt_wait
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state, next_state;
    logic   ready, cond, capture, wait_inc;
    logic   rd1_zero, rd1_neg;
    logic   done_q, jump_q;

    assign rd1_zero = (bus.rd1 == '0);
    assign rd1_neg  = bus.rd1[WIDTH-1];

    always_comb begin
        ready = 1'b1;
        cond  = 1'b0;
        case (bus.br_op)
            3'd0: begin ready = bus.rd1_ready & bus.rd2_ready; cond = (bus.rd1 == bus.rd2); end
            3'd1: begin ready = bus.rd1_ready & bus.rd2_ready; cond = (bus.rd1 != bus.rd2); end
            3'd2: begin ready = bus.rd1_ready; cond = rd1_neg | rd1_zero; end
            3'd3: begin ready = bus.rd1_ready; cond = !rd1_neg && !rd1_zero; end
            3'd4: begin ready = bus.rd1_ready; cond = rd1_neg; end
            3'd5: begin ready = bus.rd1_ready; cond = !rd1_neg; end
            3'd6: cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        wait_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.br_valid && !bus.flush) begin
                    if (ready) begin
                        capture    = 1'b1;
                        next_state = RESOLVE;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.flush) begin
                    next_state = IDLE;
                end else if (ready) begin
                    capture    = 1'b1;
                    next_state = RESOLVE;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            RESOLVE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            done_q <= 1'b0;
            jump_q <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= capture;
            jump_q <= capture & cond;
        end
    end

    // Clear takes priority over any increment landing on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_branch <= '0;
            cnt_taken  <= '0;
            cnt_wait   <= '0;
        end else if (clr_cnt) begin
            cnt_branch <= '0;
            cnt_taken  <= '0;
            cnt_wait   <= '0;
        end else begin
            if (capture && cnt_branch != CNT_MAX)
                cnt_branch <= cnt_branch + 1'b1;
            if (capture && cond && cnt_taken != CNT_MAX)
                cnt_taken <= cnt_taken + 1'b1;
            if (wait_inc && cnt_wait != CNT_MAX)
                cnt_wait <= cnt_wait + 1'b1;
        end
    end

    assign bus.cmp_stall = bus.br_valid && (state != RESOLVE) && reset;
    assign bus.b_done    = done_q;
    assign bus.b_jump    = jump_q;
endmodule

// File: tb/tb_d_branch_resolve_unit.sv
// Directed bench for d_branch_resolve_unit with CNT_W=4 so counter saturation is reachable.
module tb_d_branch_resolve_unit;
    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             clr_cnt;
    logic [CNT_W-1:0] cnt_branch, cnt_taken, cnt_wait;
    int               total;
    int               bad;

    d_branch_resolve_unit_if #(.WIDTH(WIDTH)) bus ();

    d_branch_resolve_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .clr_cnt    (clr_cnt),
        .cnt_branch (cnt_branch),
        .cnt_taken  (cnt_taken),
        .cnt_wait   (cnt_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input int b, input int t, input int w);
        check({tag, "_cnt_branch"}, 32'(cnt_branch), 32'(b));
        check({tag, "_cnt_taken"},  32'(cnt_taken),  32'(t));
        check({tag, "_cnt_wait"},   32'(cnt_wait),   32'(w));
    endtask

    task automatic signed_br(input string tag, input logic [2:0] op, input logic [31:0] v,
                             input logic exp_jump);
        bus.br_valid = 1'b1;
        bus.br_op    = op;
        bus.rd1      = v;
        bus.rd2      = 32'hDEAD_BEEF;
        #1;
        check({tag, "_stall"}, 32'(bus.cmp_stall), 32'd1);
        tick();
        check({tag, "_done"}, 32'(bus.b_done), 32'd1);
        check({tag, "_jump"}, 32'(bus.b_jump), 32'(exp_jump));
        bus.br_valid = 1'b0;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        clr_cnt = 1'b0;
        bus.br_valid  = 1'b1;
        bus.br_op     = 3'd0;
        bus.rd1       = '0;
        bus.rd2       = '0;
        bus.rd1_ready = 1'b1;
        bus.rd2_ready = 1'b1;
        bus.flush     = 1'b0;
        #12;
        check("rst_stall", 32'(bus.cmp_stall), 32'd0);
        check("rst_done",  32'(bus.b_done),    32'd0);
        check("rst_jump",  32'(bus.b_jump),    32'd0);
        check_cnt("rst", 0, 0, 0);
        bus.br_valid = 1'b0;
        #10;
        reset = 1'b1;
        tick();

        // BEQ with equal operands, both ready
        bus.br_valid = 1'b1;
        bus.br_op    = 3'd0;
        bus.rd1      = 32'h0000_1234;
        bus.rd2      = 32'h0000_1234;
        #1;
        check("beq_stall_c0", 32'(bus.cmp_stall), 32'd1);
        tick();
        check("beq_done", 32'(bus.b_done), 32'd1);
        check("beq_jump", 32'(bus.b_jump), 32'd1);
        check("beq_stall_c1", 32'(bus.cmp_stall), 32'd0);
        check_cnt("beq", 1, 1, 0);
        bus.br_valid = 1'b0;
        bus.rd1      = 32'h0;
        tick();
        check("beq_done_drop", 32'(bus.b_done), 32'd0);
        check("beq_jump_drop", 32'(bus.b_jump), 32'd0);

        // BNE equal operands, rd2 late
        bus.br_valid  = 1'b1;
        bus.br_op     = 3'd1;
        bus.rd1       = 32'd5;
        bus.rd2       = 32'd5;
        bus.rd2_ready = 1'b0;
        #1;
        check("bne_stall_c0", 32'(bus.cmp_stall), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bne_wait_stall", 32'(bus.cmp_stall), 32'd1);
            check("bne_wait_done",  32'(bus.b_done),    32'd0);
        end
        tick();
        check("bne_cnt_wait_pre", 32'(cnt_wait), 32'd3);
        bus.rd2_ready = 1'b1;
        tick();
        check("bne_done", 32'(bus.b_done), 32'd1);
        check("bne_jump", 32'(bus.b_jump), 32'd0);
        check_cnt("bne", 2, 1, 3);
        bus.br_valid = 1'b0;
        tick();

        // Signed single-operand ops; rd2 never ready, must not stall resolution
        bus.rd2_ready = 1'b0;
        signed_br("bltz_min", 3'd4, 32'h8000_0000, 1'b1);
        signed_br("blez_min", 3'd2, 32'h8000_0000, 1'b1);
        signed_br("bgtz_min", 3'd3, 32'h8000_0000, 1'b0);
        signed_br("bgez_min", 3'd5, 32'h8000_0000, 1'b0);
        signed_br("blez_zero", 3'd2, 32'h0, 1'b1);
        signed_br("bgez_zero", 3'd5, 32'h0, 1'b1);
        signed_br("bgtz_pos", 3'd3, 32'h7FFF_FFFF, 1'b1);
        signed_br("bltz_zero", 3'd4, 32'h0, 1'b0);
        signed_br("rsvd", 3'd7, 32'h8000_0000, 1'b0);
        check_cnt("signed", 11, 6, 3);

        // Flush while waiting
        bus.br_valid = 1'b1;
        bus.br_op    = 3'd0;
        tick();
        bus.flush = 1'b1;
        tick();
        check("flw_done", 32'(bus.b_done), 32'd0);
        bus.flush     = 1'b0;
        bus.br_valid  = 1'b0;
        bus.rd2_ready = 1'b1;
        #1;
        check("flw_stall", 32'(bus.cmp_stall), 32'd0);
        tick();
        check("flw_done_after", 32'(bus.b_done), 32'd0);
        check_cnt("flw", 11, 6, 3);

        // Flush in IDLE coinciding with ready operands
        bus.br_valid = 1'b1;
        bus.flush    = 1'b1;
        bus.rd1      = 32'd9;
        bus.rd2      = 32'd9;
        tick();
        check("fli_done", 32'(bus.b_done), 32'd0);
        bus.br_valid = 1'b0;
        bus.flush    = 1'b0;
        tick();
        check("fli_done_after", 32'(bus.b_done), 32'd0);
        check_cnt("fli", 11, 6, 3);

        // Flush during RESOLVE does not retract the decision
        bus.br_valid = 1'b1;
        bus.br_op    = 3'd6;
        tick();
        bus.flush = 1'b1;
        #1;
        check("flr_done", 32'(bus.b_done), 32'd1);
        check("flr_jump", 32'(bus.b_jump), 32'd1);
        bus.flush    = 1'b0;
        bus.br_valid = 1'b0;
        tick();
        check_cnt("flr", 12, 7, 3);

        // Clear, then 17 back-to-back ALWAYS branches saturating 4-bit counters
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check_cnt("clr", 0, 0, 0);
        bus.br_valid = 1'b1;
        bus.br_op    = 3'd6;
        for (int i = 0; i < 17; i++) begin
            tick();
            check("b2b_done_hi", 32'(bus.b_done), 32'd1);
            tick();
            check("b2b_done_lo", 32'(bus.b_done), 32'd0);
        end
        bus.br_valid = 1'b0;
        check_cnt("sat", 15, 15, 0);
        tick();

        // Clear on an increment edge wins
        bus.br_valid = 1'b1;
        clr_cnt      = 1'b1;
        tick();
        clr_cnt      = 1'b0;
        bus.br_valid = 1'b0;
        check("clrinc_done", 32'(bus.b_done), 32'd1);
        check_cnt("clrinc", 0, 0, 0);
        tick();
        bus.br_valid = 1'b1;
        tick();
        bus.br_valid = 1'b0;
        check_cnt("postclr", 1, 1, 0);
        tick();

        // Reset asserted mid-WAIT
        bus.br_valid  = 1'b1;
        bus.br_op     = 3'd0;
        bus.rd2_ready = 1'b0;
        tick();
        tick();
        check("rw_cnt_wait", 32'(cnt_wait), 32'd1);
        reset = 1'b0;
        #1;
        check("rw_stall", 32'(bus.cmp_stall), 32'd0);
        check("rw_done",  32'(bus.b_done),    32'd0);
        check_cnt("rw", 0, 0, 0);
        #3;
        reset         = 1'b1;
        bus.rd2_ready = 1'b1;
        #1;
        check("rw_rel_stall", 32'(bus.cmp_stall), 32'd1);
        tick();
        check("rw_rel_done", 32'(bus.b_done), 32'd1);
        check("rw_rel_jump", 32'(bus.b_jump), 32'd1);
        bus.br_valid = 1'b0;

        // Reset asserted mid-RESOLVE drops the pending decision
        reset = 1'b0;
        #1;
        check("rr_done", 32'(bus.b_done), 32'd0);
        check("rr_jump", 32'(bus.b_jump), 32'd0);
        #2;
        reset = 1'b1;
        tick();
        check("rr_done_after", 32'(bus.b_done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/d_branch_resolve_unit.md
Name: d_branch_resolve_unit

Overview:
- Parametrised decode-stage branch resolver.
- Evaluates six MIPS branch conditions (signed compare) on forwarded operands.
- Waits with a stall handshake while operands are not yet forwardable, then delivers a registered one-cycle taken/done decision to fetch.
- Keeps saturating branch statistics counters for the performance-debug path.

Parameters:
WIDTH, 32, operand width in bits
CNT_W, 16, width of each statistics counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
br_valid  in  1  D-stage instruction is a branch; held high until b_done
br_op  in  3  0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ, 6 ALWAYS, 7 reserved
rd1  in  WIDTH  forwarded rs value
rd2  in  WIDTH  forwarded rt value
rd1_ready  in  1  rd1 is final (no pending producer)
rd2_ready  in  1  rd2 is final
flush  in  1  kill the in-flight D-stage branch
clr_cnt  in  1  synchronous clear of all counters
cmp_stall  out  1  combinational; D stage must hold
b_done  out  1  registered; decision valid this cycle
b_jump  out  1  registered; branch taken (only meaningful with b_done)
cnt_branch  out  CNT_W  resolved branches
cnt_taken  out  CNT_W  resolved taken branches
cnt_wait  out  CNT_W  cycles spent in WAIT

Behaviour:
- Reset (reset=0, async): state=IDLE; b_done=0, b_jump=0, all counters=0; cmp_stall forced 0 while reset=0.
- Operand need:
  - ops 0,1 need rd1_ready and rd2_ready.
  - ops 2-5 need rd1_ready only.
  - ops 6,7 need nothing.
  - ready = all needed readies high.
- Condition (signed, WIDTH bits):
  - BEQ rd1==rd2; BNE rd1!=rd2.
  - BLEZ rd1<=0; BGTZ rd1>0; BLTZ rd1<0; BGEZ rd1>=0.
  - ALWAYS 1; reserved 0.
  - rd2 is ignored for ops 2-7.
- States IDLE, WAIT, RESOLVE:
  - IDLE: if br_valid && !flush: ready -> capture cond into b_jump, b_done<=1, go RESOLVE; else go WAIT. Otherwise stay.
  - WAIT: flush -> IDLE, no outputs, no counts. Else ready -> capture cond, b_done<=1, go RESOLVE. Else stay and increment cnt_wait.
  - RESOLVE: b_done=1 and b_jump hold for exactly this cycle. Next edge: b_done<=0, b_jump<=0, go IDLE. br_valid and flush are ignored (decision already delivered).
- cmp_stall = br_valid && state!=RESOLVE && reset.
- Handshake: the D register advances only on the RESOLVE cycle.
- Minimum latency: branch presented in cycle n with ready operands gives b_done in cycle n+1. Each branch costs at least one stall cycle.
- Back-to-back branches: the new br_valid is seen in the IDLE cycle after RESOLVE, giving minimum spacing of 2 cycles.
- Condition uses rd1/rd2 sampled at the capturing edge only. Later operand changes do not alter b_jump.
- flush in IDLE or WAIT on the same cycle as ready: flush wins, no resolution.
- Counters:
  - Update on the edge entering RESOLVE: cnt_branch+1, and cnt_taken+1 if cond.
  - All counters saturate at 2^CNT_W-1 (no wrap).
  - clr_cnt=1 zeroes all counters at the edge and wins over a simultaneous increment.
- Reset asserted mid-WAIT or mid-RESOLVE: immediate return to the reset values; no pending decision survives.

Test Plan:
- BEQ, rd1=rd2=0x00001234, both ready at cycle 0 -> cmp_stall=1 cycle 0; cycle 1 b_done=1, b_jump=1, cmp_stall=0; cnt_branch=1, cnt_taken=1.
- BNE, rd1=5, rd2=5, rd2_ready low for 3 cycles -> WAIT for 3 cycles with cmp_stall=1; then b_done=1, b_jump=0; cnt_wait=3, cnt_taken=0.
- Signed ops, rd1=0x80000000 -> BLTZ taken, BLEZ taken, BGTZ not taken, BGEZ not taken. With rd1=0 -> BLEZ and BGEZ taken. rd2_ready=0 throughout causes no stall.
- Flush in WAIT, and flush in IDLE coinciding with ready -> return to IDLE, b_done never asserts, counters unchanged. Flush in RESOLVE -> b_done still 1.
- CNT_W=4, 17 taken ALWAYS branches back-to-back -> cnt_branch=cnt_taken=15 (saturated); b_done pulses every 2 cycles. clr_cnt on an increment edge -> counters 0.
- Reset low during WAIT with br_valid high -> b_done=0, cmp_stall=0 immediately. After release with ready operands -> resolves in 1 cycle from IDLE.
